// File: rtl/fmsynth_cmdplayer.sv
// Command player: FIFO of queued register writes/delays replayed onto the fmsynth write bus.
// Optional delay engine enabled by defining FMSYNTH_CMDPLAYER_DELAY_EN.
module fmsynth_cmdplayer #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DELAY_WIDTH     = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               cmd_addr,
  input  logic [31:0]              cmd_data,
  input  logic                     cmd_delay,
  input  logic                     cmd_push,
  input  logic                     flush,
  output logic                     cmd_full,
  output logic [FIFO_DEPTH_LOG2:0] cmd_level,
  output logic                     overflow,
  output logic                     busy,
  output logic [7:0]               bus_addr,
  output logic [31:0]              bus_wrdata,
  output logic                     bus_wren,
  input  logic                     bus_wait
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int ENTRY_W = 41;
  localparam logic [FIFO_DEPTH_LOG2:0]   LVL_ONE  = (FIFO_DEPTH_LOG2+1)'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   LVL_FULL = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);

  if (DELAY_WIDTH < 1 || DELAY_WIDTH > 32) begin : g_bad_delay_width
    $error("DELAY_WIDTH must be within 1..32");
  end

`ifdef FMSYNTH_CMDPLAYER_DELAY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_DELAY = 2'd2} state_t;
  localparam logic [DELAY_WIDTH-1:0] CNT_ONE = DELAY_WIDTH'(1);
  logic [DELAY_WIDTH-1:0] delay_cnt_r;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1} state_t;
`endif

  state_t                     state_r, state_nxt_s;
  logic [ENTRY_W-1:0]         mem_r [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_DEPTH_LOG2:0]   level_r, level_nxt_s;
  logic                       cmd_full_r, overflow_r, busy_r, bus_wren_r;
  logic [7:0]                 bus_addr_r;
  logic [31:0]                bus_wrdata_r;
  logic [ENTRY_W-1:0]         head_s;
  logic                       head_delay_s, push_ok_s, pop_s;

  assign head_s       = mem_r[rd_ptr_r];
  assign head_delay_s = head_s[40];
  // Flush wins over push and also suppresses the pop on the same edge.
  assign push_ok_s    = cmd_push && !cmd_full_r && !flush;
  assign pop_s        = (state_r == ST_IDLE) && (level_r != '0) && !flush;

  assign cmd_full   = cmd_full_r;
  assign cmd_level  = level_r;
  assign overflow   = overflow_r;
  assign busy       = busy_r;
  assign bus_addr   = bus_addr_r;
  assign bus_wrdata = bus_wrdata_r;
  assign bus_wren   = bus_wren_r;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= {cmd_delay, cmd_addr, cmd_data};
    end
  end

  // FIFO occupancy after this edge
  always_comb begin
    level_nxt_s = level_r;
    if (flush) begin
      level_nxt_s = '0;
    end else if (push_ok_s && !pop_s) begin
      level_nxt_s = level_r + LVL_ONE;
    end else if (!push_ok_s && pop_s) begin
      level_nxt_s = level_r - LVL_ONE;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Player next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s && !head_delay_s) begin
          state_nxt_s = ST_WRITE;
`ifdef FMSYNTH_CMDPLAYER_DELAY_EN
        end else if (pop_s && head_delay_s) begin
          state_nxt_s = ST_DELAY;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!bus_wait) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
`ifdef FMSYNTH_CMDPLAYER_DELAY_EN
      ST_DELAY: begin
        if (flush || (delay_cnt_r == '0)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DELAY;
        end
      end
`endif
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, pointers, status flags and bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      level_r      <= '0;
      cmd_full_r   <= 1'b0;
      overflow_r   <= 1'b0;
      busy_r       <= 1'b0;
      bus_wren_r   <= 1'b0;
      bus_addr_r   <= 8'h00;
      bus_wrdata_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt_s;
      level_r    <= level_nxt_s;
      cmd_full_r <= (level_nxt_s == LVL_FULL);
      busy_r     <= (state_nxt_s != ST_IDLE) || (level_nxt_s != '0);
      bus_wren_r <= (state_nxt_s == ST_WRITE);
      if (flush) begin
        wr_ptr_r   <= '0;
        rd_ptr_r   <= '0;
        overflow_r <= 1'b0;
      end else begin
        if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
        if (cmd_push && cmd_full_r) overflow_r <= 1'b1;
      end
      if (pop_s && !head_delay_s) begin
        bus_addr_r   <= head_s[39:32];
        bus_wrdata_r <= head_s[31:0];
      end
    end
  end

`ifdef FMSYNTH_CMDPLAYER_DELAY_EN
  // Delay countdown; reaching zero releases the player on the following edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      delay_cnt_r <= '0;
    end else if (pop_s && head_delay_s) begin
      delay_cnt_r <= head_s[DELAY_WIDTH-1:0];
    end else if ((state_r == ST_DELAY) && (delay_cnt_r != '0)) begin
      delay_cnt_r <= delay_cnt_r - CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_fmsynth_cmdplayer.sv
// Self-checking bench for fmsynth_cmdplayer: directed timing scenarios plus a randomized
// command stream compared against an in-order expected-write list.
module tb_fmsynth_cmdplayer;

`ifdef FMSYNTH_CMDPLAYER_DELAY_EN
  localparam int DELAY_GAP = 14;
`else
  localparam int DELAY_GAP = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [31:0] cmd_data = 32'h0;
  logic        cmd_delay = 1'b0, cmd_push = 1'b0, flush = 1'b0, bus_wait = 1'b0;
  logic        cmd_full, overflow, busy, bus_wren;
  logic [4:0]  cmd_level;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wrdata;

  int checks = 0, failures = 0, cyc = 0;
  bit rand_wait = 1'b0;

  int          start_q[$];
  logic [7:0]  comp_addr_q[$];
  logic [31:0] comp_data_q[$];
  int          comp_cyc_q[$];
  int          wren_high_cnt = 0, unstable_cnt = 0;
  logic        prev_wren = 1'b0;
  logic [7:0]  prev_addr = 8'h00;
  logic [31:0] prev_data = 32'h0;

  fmsynth_cmdplayer dut (
    .clk(clk), .reset_n(reset_n), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_delay(cmd_delay), .cmd_push(cmd_push), .flush(flush), .cmd_full(cmd_full),
    .cmd_level(cmd_level), .overflow(overflow), .busy(busy), .bus_addr(bus_addr),
    .bus_wrdata(bus_wrdata), .bus_wren(bus_wren), .bus_wait(bus_wait)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // Bus-slave monitor: records write starts, completions and stability
  always @(negedge clk) begin
    if (bus_wren) begin
      wren_high_cnt <= wren_high_cnt + 1;
      if (prev_wren && ((bus_addr !== prev_addr) || (bus_wrdata !== prev_data)))
        unstable_cnt <= unstable_cnt + 1;
      if (!prev_wren) start_q.push_back(cyc);
      if (!bus_wait) begin
        comp_addr_q.push_back(bus_addr);
        comp_data_q.push_back(bus_wrdata);
        comp_cyc_q.push_back(cyc);
      end
    end
    prev_wren <= bus_wren;
    prev_addr <= bus_addr;
    prev_data <= bus_wrdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_wait) bus_wait = ($urandom_range(0, 3) == 0);
  endtask

  task automatic do_push(input logic d, input logic [7:0] a, input logic [31:0] x);
    cmd_delay = d; cmd_addr = a; cmd_data = x; cmd_push = 1'b1;
    tick();
    cmd_push = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int when);
    bit done = 1'b0;
    when = -1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && !bus_wren) begin done = 1'b1; when = cyc; end
    end
    checks++;
    if (!done) begin failures++; $display("FAIL wait_idle: still busy after %0d cycles", budget); end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_wren !== 1'b0) begin failures++; $display("FAIL reset_wren: got %b exp 0", bus_wren); end
    checks++; if (bus_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %h exp 00", bus_addr); end
    checks++; if (bus_wrdata !== 32'h0) begin failures++; $display("FAIL reset_data: got %h exp 0", bus_wrdata); end
    checks++; if ({cmd_full, overflow, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b exp 000", {cmd_full, overflow, busy}); end
    checks++; if (cmd_level !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d exp 0", cmd_level); end
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int cb = comp_addr_q.size();
    do_push(1'b0, 8'h80, 32'h003F_0079);
    @(negedge clk);
    checks++; if ({cmd_level, bus_wren, busy} !== {5'd1, 1'b0, 1'b1}) begin failures++; $display("FAIL single_queued: level/wren/busy got %0d/%b/%b exp 1/0/1", cmd_level, bus_wren, busy); end
    tick(); @(negedge clk);
    checks++; if ({bus_wren, bus_addr, bus_wrdata} !== {1'b1, 8'h80, 32'h003F_0079}) begin failures++; $display("FAIL single_issue: wren/addr/data got %b/%h/%h exp 1/80/003f0079", bus_wren, bus_addr, bus_wrdata); end
    checks++; if (cmd_level !== 5'd0) begin failures++; $display("FAIL single_level: got %0d exp 0", cmd_level); end
    tick(); @(negedge clk);
    checks++; if ({bus_wren, busy} !== 2'b00) begin failures++; $display("FAIL single_done: wren/busy got %b/%b exp 0/0", bus_wren, busy); end
    checks++; if (comp_addr_q.size() - cb !== 1) begin failures++; $display("FAIL single_count: got %0d exp 1", comp_addr_q.size() - cb); end
    tick();
  endtask

  task automatic test_wait_write();
    int cb = comp_addr_q.size();
    int hb = wren_high_cnt;
    int ub = unstable_cnt;
    int when;
    bus_wait = 1'b1;
    do_push(1'b0, 8'h80, 32'h003F_0079);
    tick();
    repeat (3) tick();
    bus_wait = 1'b0;
    wait_idle(20, when);
    checks++; if (wren_high_cnt - hb !== 4) begin failures++; $display("FAIL wait_len: wren high %0d cycles exp 4", wren_high_cnt - hb); end
    checks++; if (unstable_cnt !== ub) begin failures++; $display("FAIL wait_stable: %0d changes exp 0", unstable_cnt - ub); end
    checks++; if (comp_addr_q.size() - cb !== 1) begin failures++; $display("FAIL wait_count: got %0d exp 1", comp_addr_q.size() - cb); end
    else begin
      checks++; if ({comp_addr_q[cb], comp_data_q[cb]} !== {8'h80, 32'h003F_0079}) begin failures++; $display("FAIL wait_data: got %h/%h exp 80/003f0079", comp_addr_q[cb], comp_data_q[cb]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a [3] = '{8'h80, 8'h82, 8'h60};
    int sb = start_q.size();
    int cb = comp_addr_q.size();
    int p, when;
    do_push(1'b0, exp_a[0], 32'h1111_0000);
    p = cyc;
    do_push(1'b0, exp_a[1], 32'h2222_0000);
    do_push(1'b0, exp_a[2], 32'h3333_0000);
    wait_idle(30, when);
    checks++; if (start_q.size() - sb !== 3 || comp_addr_q.size() - cb !== 3) begin failures++; $display("FAIL b2b_count: starts %0d comps %0d exp 3", start_q.size() - sb, comp_addr_q.size() - cb); end
    else begin
      checks++; if (start_q[sb] !== p + 1) begin failures++; $display("FAIL b2b_latency: start %0d exp %0d", start_q[sb], p + 1); end
      for (int i = 0; i < 3; i++) begin
        checks++; if (comp_addr_q[cb+i] !== exp_a[i]) begin failures++; $display("FAIL b2b_order[%0d]: got %h exp %h", i, comp_addr_q[cb+i], exp_a[i]); end
        if (i > 0) begin
          checks++; if (start_q[sb+i] - start_q[sb+i-1] !== 2) begin failures++; $display("FAIL b2b_spacing[%0d]: got %0d exp 2", i, start_q[sb+i] - start_q[sb+i-1]); end
        end
      end
      checks++; if (when !== comp_cyc_q[cb+2] + 1) begin failures++; $display("FAIL b2b_busy_fall: cycle %0d exp %0d", when, comp_cyc_q[cb+2] + 1); end
    end
  endtask

  task automatic test_delay();
    int sb = start_q.size();
    int cb = comp_addr_q.size();
    int when;
    do_push(1'b0, 8'h10, 32'hAAAA_0001);
    do_push(1'b1, 8'h00, 32'hFF00_000A);
    do_push(1'b0, 8'h11, 32'hAAAA_0002);
    wait_idle(60, when);
    checks++; if (comp_addr_q.size() - cb !== 2 || start_q.size() - sb !== 2) begin failures++; $display("FAIL delay_count: comps %0d exp 2", comp_addr_q.size() - cb); end
    else begin
      checks++; if (start_q[sb+1] - comp_cyc_q[cb] !== DELAY_GAP) begin failures++; $display("FAIL delay_gap: got %0d exp %0d", start_q[sb+1] - comp_cyc_q[cb], DELAY_GAP); end
      checks++; if (comp_addr_q[cb+1] !== 8'h11) begin failures++; $display("FAIL delay_second: got %h exp 11", comp_addr_q[cb+1]); end
    end
  endtask

  task automatic test_overflow();
    int cb = comp_addr_q.size();
    int when;
    bus_wait = 1'b1;
    for (int i = 0; i < 17; i++) do_push(1'b0, 8'h20 + 8'(i), 32'hA000_0000 + 32'(i));
    @(negedge clk);
    checks++; if ({cmd_full, cmd_level, overflow, bus_wren} !== {1'b1, 5'd16, 1'b0, 1'b1}) begin failures++; $display("FAIL ovf_full: full/level/ovf/wren got %b/%0d/%b/%b exp 1/16/0/1", cmd_full, cmd_level, overflow, bus_wren); end
    do_push(1'b0, 8'hEE, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++; if ({overflow, cmd_level} !== {1'b1, 5'd16}) begin failures++; $display("FAIL ovf_set: ovf/level got %b/%0d exp 1/16", overflow, cmd_level); end
    flush = 1'b1;
    do_push(1'b0, 8'hDD, 32'h0BAD_0BAD);
    flush = 1'b0;
    @(negedge clk);
    checks++; if ({cmd_full, cmd_level, overflow, bus_wren, busy} !== {1'b0, 5'd0, 1'b0, 1'b1, 1'b1}) begin failures++; $display("FAIL ovf_flush: full/level/ovf/wren/busy got %b/%0d/%b/%b/%b exp 0/0/0/1/1", cmd_full, cmd_level, overflow, bus_wren, busy); end
    tick();
    bus_wait = 1'b0;
    wait_idle(20, when);
    checks++; if (comp_addr_q.size() - cb !== 1) begin failures++; $display("FAIL ovf_inflight: comps %0d exp 1", comp_addr_q.size() - cb); end
    else begin
      checks++; if ({comp_addr_q[cb], comp_data_q[cb]} !== {8'h20, 32'hA000_0000}) begin failures++; $display("FAIL ovf_data: got %h/%h exp 20/a0000000", comp_addr_q[cb], comp_data_q[cb]); end
    end
  endtask

  task automatic test_reset_mid();
    int sb;
    bus_wait = 1'b1;
    do_push(1'b0, 8'h40, 32'h0000_0040);
    do_push(1'b0, 8'h41, 32'h0000_0041);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({bus_wren, busy, cmd_level} !== {1'b0, 1'b0, 5'd0}) begin failures++; $display("FAIL rst_write: wren/busy/level got %b/%b/%0d exp 0/0/0", bus_wren, busy, cmd_level); end
    #1 reset_n = 1'b1;
    bus_wait = 1'b0;
    sb = start_q.size();
    repeat (10) tick();
    checks++; if (start_q.size() !== sb) begin failures++; $display("FAIL rst_write_quiet: %0d writes after release exp 0", start_q.size() - sb); end
    do_push(1'b1, 8'h00, 32'h0000_0028);
    tick();
    @(negedge clk);
`ifdef FMSYNTH_CMDPLAYER_DELAY_EN
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_delay_busy: got %b exp 1", busy); end
`endif
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({bus_wren, busy} !== 2'b00) begin failures++; $display("FAIL rst_delay: wren/busy got %b/%b exp 0/0", bus_wren, busy); end
    #1 reset_n = 1'b1;
    sb = start_q.size();
    repeat (10) tick();
    checks++; if (start_q.size() !== sb || busy !== 1'b0) begin failures++; $display("FAIL rst_delay_quiet: writes %0d busy %b exp 0/0", start_q.size() - sb, busy); end
  endtask

  task automatic test_random();
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    int cb = comp_addr_q.size();
    int sb = start_q.size();
    int ub = unstable_cnt;
    int when;
    logic d;
    logic [7:0] a;
    logic [31:0] x;
    rand_wait = 1'b1;
    for (int n = 0; n < 60; n++) begin
      d = ($urandom_range(0, 3) == 0);
      a = 8'($urandom);
      x = d ? {8'($urandom), 24'($urandom_range(0, 6))} : $urandom;
      if (!d) begin exp_addr.push_back(a); exp_data.push_back(x); end
      repeat ($urandom_range(0, 2)) tick();
      for (int g = 0; g < 50; g++) begin
        @(negedge clk);
        if (!cmd_full) break;
        tick();
      end
      do_push(d, a, x);
    end
    wait_idle(3000, when);
    rand_wait = 1'b0;
    bus_wait = 1'b0;
    checks++; if (comp_addr_q.size() - cb !== exp_addr.size()) begin failures++; $display("FAIL rnd_count: got %0d exp %0d", comp_addr_q.size() - cb, exp_addr.size()); end
    else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        checks++; if ({comp_addr_q[cb+i], comp_data_q[cb+i]} !== {exp_addr[i], exp_data[i]}) begin failures++; $display("FAIL rnd_write[%0d]: got %h/%h exp %h/%h", i, comp_addr_q[cb+i], comp_data_q[cb+i], exp_addr[i], exp_data[i]); end
      end
    end
    for (int i = sb + 1; i < start_q.size(); i++) begin
      checks++; if (start_q[i] - start_q[i-1] < 2) begin failures++; $display("FAIL rnd_spacing[%0d]: got %0d exp >=2", i, start_q[i] - start_q[i-1]); end
    end
    checks++; if (unstable_cnt !== ub || overflow !== 1'b0) begin failures++; $display("FAIL rnd_stable_ovf: changes %0d ovf %b exp 0/0", unstable_cnt - ub, overflow); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wait_write();
    test_back_to_back();
    test_delay();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
